square_seq: RTL
===============

// Module: square_seq
// PURPOSE
//  Sequential shift-add squarer: returns x*x for an unsigned IN_W-bit operand.
//  Inverse of the sqrt LUT path; a SqrtLut output fed back here lets the bench
//  round-trip sqrt results (sq_o <= original sqrt_lut_i < (sqrt_lut_o+1)^2).
//  Valid/ready on both sides; one operand in flight; IN_W cycles per operand.
// PARAMETERS
//  IN_W   8         operand width (unsigned), >= 2
//  OUT_W  2*IN_W    result width; must equal 2*IN_W (no truncation)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  val_i     in   1      operand valid
//  rdy_o     out  1      block can accept operand this cycle
//  sq_i      in   IN_W   operand x, unsigned
//  val_o     out  1      result valid
//  rdy_i     in   1      downstream accepts result this cycle
//  sq_o      out  OUT_W  result x*x, unsigned
//  busy_o    out  1      high in CALC or DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, val_o=0, sq_o=0, busy_o=0, acc=0,
//   bit counter=0, latched operand=0; rdy_o forced 0 while rst_n=0.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE: rdy_o=1. val_i&rdy_o at edge -> latch sq_i to op, acc<=0, cnt<=0,
//    go CALC. val_i=0 -> stay IDLE.
//  - CALC: rdy_o=0, val_o=0. Each cycle: if op[cnt] then acc<=acc+(op<<cnt);
//    cnt<=cnt+1. When cnt==IN_W-1 the final add completes and state->DONE
//    with sq_o<=final acc. Exactly IN_W cycles in CALC.
//  - DONE: val_o=1, sq_o held stable until handshake (val_o&rdy_i).
//    rdy_o = rdy_i (combinational). On rdy_i=1: result consumed; if val_i=1
//    in the same cycle, latch new operand and go CALC (no idle bubble),
//    else go IDLE. rdy_i=0: stay DONE, sq_o/val_o unchanged, input ignored.
//  Latency: accept at edge E -> val_o high after edge E+IN_W.
//  Throughput: back-to-back, one result per IN_W+1 cycles with rdy_i=1.
//  Arithmetic: acc is OUT_W bits; max (2^IN_W-1)^2 fits, no overflow/wrap.
//  sq_o only updates on CALC->DONE; retains last value in IDLE.
//  val_i while CALC: ignored, not queued (rdy_o=0); sq_i may change freely.
//  Reset asserted mid-CALC or mid-DONE: operation discarded, no val_o
//   pulse after release; first cycle after release is IDLE with rdy_o=1.
//  No X on outputs after reset regardless of sq_i/val_i values.
// TESTING
//  1 sq_i=0x00, val_i one cycle, rdy_i=1 -> val_o 1 cycle after 8 cycles, sq_o=0x0000.
//  2 sq_i=0xFF -> sq_o=0xFE01; sq_i=0x0F -> 0x00E1; sq_i=0x80 -> 0x4000.
//  3 Back-to-back 0x03,0x10,0xC8 with val_i held, rdy_i=1 -> sq_o 0x0009,
//    0x0100,0x9C40 at 9-cycle spacing, rdy_o high only on handshake cycles.
//  4 Backpressure: sq_i=0x7B, rdy_i=0 for 5 cycles in DONE -> val_o and
//    sq_o=0x3B19 held stable 5 cycles; rdy_o=0; released on rdy_i=1.
//  5 rst_n pulsed low at CALC cycle 4 of sq_i=0xAA -> all outputs 0 at once,
//    no val_o after release; next op 0x02 -> sq_o=0x0004.
//  6 Sweep 0..255 with random rdy_i stalls, compared to x*x; feed SqrtLut
//    vectors back: sqrt_lut_o^2 <= sqrt_lut_i < (sqrt_lut_o+1)^2 for all 1024.

Source files
------------

// File: rtl/square_seq.sv
// -----------------------------------------------------------------------------
// square_seq
//   Sequential shift-add squarer. Returns x*x for an unsigned IN_W-bit operand
//   and spends IN_W cycles per operand. One operand is in flight at a time.
//   Valid/ready handshakes are used on both the operand and the result side.
//
//   Parameters
//     IN_W   operand width (unsigned), >= 2
//     OUT_W  result width, must equal 2*IN_W so the result is never truncated
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     val_i   operand valid
//     rdy_o   block accepts an operand this cycle (forced 0 while in reset)
//     sq_i    operand x, unsigned
//     val_o   result valid (registered)
//     rdy_i   downstream accepts the result this cycle
//     sq_o    result x*x, unsigned (registered, held until consumed)
//     busy_o  high while computing or holding an unconsumed result
// -----------------------------------------------------------------------------
module square_seq #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2 * IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             val_i,
  output logic             rdy_o,
  input  logic [IN_W-1:0]  sq_i,
  output logic             val_o,
  input  logic             rdy_i,
  output logic [OUT_W-1:0] sq_o,
  output logic             busy_o
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IN_W-1:0]    op;
  logic [OUT_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [OUT_W-1:0]   acc_next;

  // Partial product for one operand bit: op shifted to that bit's weight when
  // the bit is set, zero otherwise.
  function automatic logic [OUT_W-1:0] partial_term(input logic [IN_W-1:0]  x,
                                                    input logic [CNT_W-1:0] k);
    logic [OUT_W-1:0] x_ext;
    x_ext = OUT_W'(x);
    return x[k] ? (x_ext << k) : '0;
  endfunction

  // OUT_W = 2*IN_W bits hold (2^IN_W-1)^2, so this sum can never wrap.
  assign acc_next = acc + partial_term(op, cnt);

  // Ready is combinational so a result can be consumed and a new operand
  // accepted on the same edge; reset masks it off immediately.
  assign rdy_o = rst_n & ((state == IDLE) | ((state == DONE) & rdy_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      acc    <= '0;
      cnt    <= '0;
      val_o  <= 1'b0;
      sq_o   <= '0;
      busy_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (val_i) begin
            op     <= sq_i;
            acc    <= '0;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end

        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          // The last bit's add lands directly in sq_o on the way to DONE.
          if (cnt == CNT_LAST) begin
            sq_o  <= acc_next;
            val_o <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          if (rdy_i) begin
            val_o <= 1'b0;
            if (val_i) begin
              // Consume and restart in the same cycle: no idle bubble.
              op    <= sq_i;
              acc   <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        default: begin
          val_o  <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
